ps2_interface: RTL and testbench



---
 rtl/ps2_interface.sv | 159 +++++++++++++++
 tb/tb_ps2_interface.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_interface.sv
// Receive-only PS/2 keyboard front end: synchronized frame receiver with timeout,
// two-digit hex seven-segment readout of the last byte, and a power-up delayed reset.
module ps2_interface #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int RESET_DELAY    = 1048575
) (
  input  logic       clock,
  input  logic       reset,
  inout  wire        ps2_clock,
  inout  wire        ps2_data,
  output logic [7:0] ps2_key_data,
  output logic       ps2_key_pressed,
  output logic [7:0] ps2_out,
  output logic [6:0] seg_lo,
  output logic [6:0] seg_hi,
  output logic       dly_rst
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  localparam int          TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [19:0] DLY_MAX = 20'(RESET_DELAY);

  // The pins are open-collector and owned by the keyboard; this block only listens.
  assign ps2_clock = 1'bz;
  assign ps2_data  = 1'bz;

  logic          clk_meta_q, clk_sync_q, clk_prev_q;
  logic          dat_meta_q, dat_sync_q;
  logic          fall_q, bit_q;
  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] to_q, to_d;
  logic [7:0]    key_q, key_d;
  logic          pressed_q, pressed_d;
  logic [19:0]   dly_q, dly_d;
  logic          timeout;

  // NOTE: every register in this block uses non-blocking assignment so all flops
  // sample the same pre-edge values; blocking here would collapse the synchronizer chain.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      fall_q     <= 1'b0;
      bit_q      <= 1'b1;
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      to_q       <= '0;
      key_q      <= '0;
      pressed_q  <= 1'b0;
      dly_q      <= '0;
    end else begin
      clk_meta_q <= ps2_clock;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= ps2_data;
      dat_sync_q <= dat_meta_q;
      // Data is registered alongside the edge so the bit seen matches the edge.
      fall_q     <= clk_prev_q & ~clk_sync_q;
      bit_q      <= dat_sync_q;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      to_q       <= to_d;
      key_q      <= key_d;
      pressed_q  <= pressed_d;
      dly_q      <= dly_d;
    end
  end

  assign timeout = (state_q != IDLE) && !fall_q && (to_q == TO_LAST);

  // NOTE: every signal driven here gets a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    key_d     = key_q;
    pressed_d = 1'b0;
    to_d      = (state_q == IDLE || fall_q) ? '0 : to_q + TW'(1);

    if (timeout) begin
      state_d = IDLE;
    end else if (fall_q) begin
      unique case (state_q)
        IDLE: begin
          if (!bit_q) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shift_d = {bit_q, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) state_d = PARITY;
          else                   bit_cnt_d = bit_cnt_q + 3'd1;
        end
        PARITY: begin
          parity_d = bit_q;
          state_d  = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (bit_q && (^{shift_q, parity_q})) begin
            key_d     = shift_q;
            pressed_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign dly_d   = (dly_q < DLY_MAX) ? dly_q + 20'd1 : dly_q;
  assign dly_rst = (dly_q == DLY_MAX);

  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    logic [6:0] s;
    s = 7'b1111111;
    unique case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign ps2_key_data    = key_q;
  assign ps2_out         = key_q;
  assign ps2_key_pressed = pressed_q;
  assign seg_lo          = hex_seg(key_q[3:0]);
  assign seg_hi          = hex_seg(key_q[7:4]);

endmodule

// File: tb/tb_ps2_interface.sv
// Directed bench for ps2_interface: table of frames (valid, parity and framing
// errors) plus hand sequences for reset, delayed reset, timeout and mid-frame reset.
module tb_ps2_interface;

  localparam int HALF = 20;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       pclk = 1'b1;
  logic       pdat = 1'b1;
  wire        ps2_clock_w;
  wire        ps2_data_w;
  logic [7:0] key_data, out_byte;
  logic       pressed, dly;
  logic [6:0] seg_lo, seg_hi;

  assign ps2_clock_w = pclk;
  assign ps2_data_w  = pdat;

  ps2_interface #(.TIMEOUT_CYCLES(100), .RESET_DELAY(16)) dut (
    .clock           (clk),
    .reset           (rst),
    .ps2_clock       (ps2_clock_w),
    .ps2_data        (ps2_data_w),
    .ps2_key_data    (key_data),
    .ps2_key_pressed (pressed),
    .ps2_out         (out_byte),
    .seg_lo          (seg_lo),
    .seg_hi          (seg_hi),
    .dly_rst         (dly)
  );

  always #10 clk = ~clk;

  int   n_tests  = 0;
  int   n_failed = 0;
  int   strobe_cnt = 0;
  int   wide_cnt   = 0;
  logic prev_p     = 1'b0;

  always @(negedge clk) begin
    if (pressed === 1'b1) begin
      strobe_cnt <= strobe_cnt + 1;
      if (prev_p) wide_cnt <= wide_cnt + 1;
    end
    prev_p <= (pressed === 1'b1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] seg_ref(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
          7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return t[n];
  endfunction

  // Sends the first nbits of a frame; lat is the cycle count from the final
  // stop-bit falling edge to the strobe (0 if none).
  task automatic send_frame(input logic [7:0] b, input bit par_ok, input bit stop,
                            input int nbits, output int lat);
    logic [10:0] bits;
    logic        par;
    par  = par_ok ? ~^b : ^b;
    bits = {stop, par, b, 1'b0};
    lat  = 0;
    for (int i = 0; i < nbits; i++) begin
      pdat = bits[i];
      repeat (HALF) @(negedge clk);
      pclk = 1'b0;
      for (int k = 1; k <= HALF; k++) begin
        @(negedge clk);
        if (pressed && lat == 0) lat = k;
      end
      pclk = 1'b1;
    end
    pdat = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic measure_dly(output int n);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (dly) begin
        n = k;
        break;
      end
    end
  endtask

  typedef struct {
    logic [7:0] b;
    bit         par_ok;
    bit         stop;
    bit         exp_strobe;
    logic [7:0] exp_out;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int lat, n, s0;

    vecs[0] = '{8'h1C, 1'b1, 1'b1, 1'b1, 8'h1C};
    vecs[1] = '{8'hF0, 1'b0, 1'b1, 1'b0, 8'h1C};
    vecs[2] = '{8'hF0, 1'b1, 1'b1, 1'b1, 8'hF0};
    vecs[3] = '{8'h55, 1'b1, 1'b0, 1'b0, 8'hF0};
    vecs[4] = '{8'hE0, 1'b1, 1'b1, 1'b1, 8'hE0};
    vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'h00};
    vecs[6] = '{8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF};

    // Reset state and delayed-reset timing.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_key_data", key_data, 8'h00);
    check("rst_out", out_byte, 8'h00);
    check("rst_pressed", pressed, 1'b0);
    check("rst_seg_lo", seg_lo, 7'b1000000);
    check("rst_seg_hi", seg_hi, 7'b1000000);
    check("rst_dly", dly, 1'b0);
    rst = 1'b0;
    measure_dly(n);
    check("dly_rise_cycles", n, 16);
    repeat (5) @(negedge clk);
    check("dly_stays_high", dly, 1'b1);

    // Frame table.
    foreach (vecs[i]) begin
      s0 = strobe_cnt;
      send_frame(vecs[i].b, vecs[i].par_ok, vecs[i].stop, 11, lat);
      check($sformatf("v%0d_strobes", i), strobe_cnt - s0, vecs[i].exp_strobe ? 1 : 0);
      if (vecs[i].exp_strobe) check($sformatf("v%0d_latency", i), lat, 4);
      check($sformatf("v%0d_out", i), out_byte, vecs[i].exp_out);
      check($sformatf("v%0d_key_data", i), key_data, vecs[i].exp_out);
      check($sformatf("v%0d_seg_lo", i), seg_lo, seg_ref(vecs[i].exp_out[3:0]));
      check($sformatf("v%0d_seg_hi", i), seg_hi, seg_ref(vecs[i].exp_out[7:4]));
    end

    // Partial frame abandoned by the timeout, then a full frame.
    s0 = strobe_cnt;
    send_frame(8'h3C, 1'b1, 1'b1, 4, lat);
    repeat (150) @(negedge clk);
    send_frame(8'hA5, 1'b1, 1'b1, 11, lat);
    check("timeout_strobes", strobe_cnt - s0, 1);
    check("timeout_out", out_byte, 8'hA5);

    // Reset in the middle of a frame.
    s0 = strobe_cnt;
    send_frame(8'h3C, 1'b1, 1'b1, 5, lat);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_out", out_byte, 8'h00);
    check("midrst_seg_lo", seg_lo, 7'b1000000);
    check("midrst_dly_low", dly, 1'b0);
    rst = 1'b0;
    measure_dly(n);
    check("midrst_dly_cycles", n, 16);
    check("midrst_no_strobe", strobe_cnt - s0, 0);

    // Reset during the delay count restarts it.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("cntrst_dly_low", dly, 1'b0);
    rst = 1'b0;
    measure_dly(n);
    check("cntrst_dly_cycles", n, 16);

    // Receiver still works after the resets.
    send_frame(8'h3C, 1'b1, 1'b1, 11, lat);
    check("post_out", out_byte, 8'h3C);
    check("post_latency", lat, 4);

    @(negedge clk);
    check("strobe_width", wide_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
